stopwatch_lap_ctrl: RTL and testbench
=====================================

# stopwatch_lap_ctrl

Run/stop/lap sequencer for the stopwatch datapath. Takes the raw board buttons, debounces them, and runs a small state machine. The machine drives the datapath's `run_stop` level and `clear` pulse, and freezes a lap snapshot of the live time for display while counting continues underneath. It sits between the board buttons and the stopwatch datapath, and feeds the display formatter.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz). Legal range ≥ 2.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `btn_runstop`  in  1: raw run/stop button, asynchronous to `clk`.
- `btn_clear`  in  1: raw clear button, asynchronous.
- `btn_lap`  in  1: raw lap button, asynchronous.
- `live_msec`  in  7: datapath centiseconds, 0–99.
- `live_sec`  in  6: datapath seconds, 0–59.
- `live_min`  in  6: datapath minutes, 0–59.
- `live_hour`  in  5: datapath hours, 0–23.
- `o_runstop`  out  1: level to the datapath; 1 = counting.
- `o_clear`  out  1: one-cycle clear pulse to the datapath.
- `disp_msec`  out  7: displayed time field, registered.
- `disp_sec`  out  6: displayed time field, registered.
- `disp_min`  out  6: displayed time field, registered.
- `disp_hour`  out  5: displayed time field, registered.
- `lap_active`  out  1: 1 while the display is frozen.
- `lap_count`  out  4: number of laps taken since the last clear; saturates at 15.

## Operation
- Each button passes through `btn_debounce`:
  - 2-flop synchronizer.
  - Counter that increments while the synchronized level differs from the accepted level, and resets to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the accepted level updates.
  - Output is a registered one-cycle pulse on each rising edge of the accepted level. Releases produce no pulse.
- FSM states are STOP, RUN, LAP and CLR. Reset state is STOP.
  - **STOP:**
    - runstop pulse → RUN.
    - clear pulse → CLR.
    - lap pulse is ignored.
  - **RUN:**
    - runstop pulse → STOP.
    - lap pulse → LAP: capture the `live_*` inputs into the lap registers and increment `lap_count` (saturating).
    - clear pulse is ignored.
  - **LAP:**
    - runstop pulse → STOP; the display returns to live.
    - lap pulse → RUN; the display returns to live.
    - A new lap is taken only from RUN.
    - clear pulse is ignored.
  - **CLR:** unconditional → STOP after one cycle. Clears the lap registers and `lap_count` to 0.
- Simultaneous pulses in the same cycle are resolved by priority runstop > clear > lap; lower-priority pulses are dropped, not queued.
- `o_runstop` = 1 iff the state is RUN or LAP. `o_clear` = 1 iff the state is CLR. `lap_active` = 1 iff the state is LAP. All three are decoded from the state register, so they are glitch-free.
- Display selection: the `disp_*` registers load the lap registers when the next state is LAP, else the `live_*` inputs.

## Timing
- Reset values:
  - state STOP.
  - `o_runstop`, `o_clear` and `lap_active` = 0.
  - `disp_*` = 0.
  - Lap registers and `lap_count` = 0.
  - Debounce counters, synchronizers and accepted levels = 0.
- Button latency: raw high first sampled at edge N, held stable → pulse high during the cycle after edge N+`DEBOUNCE_CYCLES`+2. The state changes at the following edge.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles resets the counter and produces no pulse.
- `o_runstop`, `o_clear` and `lap_active` change on the same edge as the state.
- Lap capture samples `live_*` on the edge that enters LAP. `disp_*` shows the snapshot from that same edge.
- In STOP and RUN, `disp_*` lags `live_*` by exactly 1 cycle.
- Reset asserted mid-debounce or mid-LAP: everything returns to reset values on the next edge. A button held through reset produces a pulse `DEBOUNCE_CYCLES`+3 cycles after reset releases, because the accepted level restarts at 0.

## Structure
- Package `stopwatch_pkg`:
  - state enum (STOP, RUN, LAP, CLR).
  - field width constants: MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
  - `LAP_CNT_W`=4.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `i_btn`, `o_pulse`), instantiated three times.
- Top level holds the FSM, lap registers, `lap_count` and display registers.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- **Reset and run/stop:** apply reset; press runstop for 10 cycles → pulse 6 cycles after the first sample; `o_runstop` goes 0→1. Second press → `o_runstop` goes back to 0.
- **Bounce rejection:** runstop toggling 1/0 every 2 cycles for 20 cycles, then held low → no pulse; state stays STOP.
- **Lap freeze:** in RUN with `live_*`=12/34/5/1, press lap → `lap_active`=1, `lap_count`=1, `disp_*` holds 12/34/5/1 while `live_*` advances. Lap again → `disp_*` tracks live one cycle later; `lap_active`=0.
- **Clear:** in STOP with `lap_count`=3, press clear → `o_clear` high exactly 1 cycle; `lap_count`=0; state STOP. Press clear in RUN → ignored, `o_clear` stays 0.
- **Simultaneous presses:** runstop and clear pulses in the same cycle from STOP → RUN, no `o_clear`. Sixteen laps → `lap_count` saturates at 15.
- **Reset mid-LAP:** assert reset while in LAP → next edge gives state STOP, `disp_*`=0 and `lap_active`=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch run/stop/lap sequencer.
package stopwatch_pkg;

  localparam int MSEC_W    = 7;
  localparam int SEC_W     = 6;
  localparam int MIN_W     = 6;
  localparam int HOUR_W    = 5;
  localparam int LAP_CNT_W = 4;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    CLR  = 2'd3
  } state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

  // Lap counter holds at its maximum instead of wrapping.
  function automatic logic [LAP_CNT_W-1:0] sat_inc(input logic [LAP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle registered pulse on each accepted press (releases are silent).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             accepted;
  logic             accepted_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      accepted   <= 1'b0;
      accepted_d <= 1'b0;
      cnt        <= '0;
      o_pulse    <= 1'b0;
    end else begin
      sync1      <= i_btn;
      sync2      <= sync1;
      accepted_d <= accepted;
      o_pulse    <= accepted & ~accepted_d;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == accepted) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        accepted <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Run/stop/lap sequencer: debounced buttons drive a STOP/RUN/LAP/CLR machine
// that controls the datapath and freezes a lap snapshot on the display.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_runstop,
  input  logic                 btn_clear,
  input  logic                 btn_lap,
  input  logic [MSEC_W-1:0]    live_msec,
  input  logic [SEC_W-1:0]     live_sec,
  input  logic [MIN_W-1:0]     live_min,
  input  logic [HOUR_W-1:0]    live_hour,
  output logic                 o_runstop,
  output logic                 o_clear,
  output logic [MSEC_W-1:0]    disp_msec,
  output logic [SEC_W-1:0]     disp_sec,
  output logic [MIN_W-1:0]     disp_min,
  output logic [HOUR_W-1:0]    disp_hour,
  output logic                 lap_active,
  output logic [LAP_CNT_W-1:0] lap_count
);

  logic   pulse_runstop;
  logic   pulse_clear;
  logic   pulse_lap;
  logic   cmd_runstop;
  logic   cmd_clear;
  logic   cmd_lap;
  state_t state;
  state_t state_next;
  time_t  live;
  time_t  lap_snap;
  time_t  disp;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_runstop (
    .clk(clk), .rst(rst), .i_btn(btn_runstop), .o_pulse(pulse_runstop)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .i_btn(btn_clear), .o_pulse(pulse_clear)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .i_btn(btn_lap), .o_pulse(pulse_lap)
  );

  // One command per cycle: runstop beats clear beats lap; losers are dropped.
  assign cmd_runstop = pulse_runstop;
  assign cmd_clear   = pulse_clear & ~pulse_runstop;
  assign cmd_lap     = pulse_lap & ~pulse_runstop & ~pulse_clear;

  assign live = {live_hour, live_min, live_sec, live_msec};

  always_comb begin
    state_next = state;
    case (state)
      STOP: begin
        if (cmd_runstop)    state_next = RUN;
        else if (cmd_clear) state_next = CLR;
      end
      RUN: begin
        if (cmd_runstop)  state_next = STOP;
        else if (cmd_lap) state_next = LAP;
      end
      LAP: begin
        if (cmd_runstop)  state_next = STOP;
        else if (cmd_lap) state_next = RUN;
      end
      CLR:     state_next = STOP;
      default: state_next = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STOP;
      o_runstop  <= 1'b0;
      o_clear    <= 1'b0;
      lap_active <= 1'b0;
      lap_snap   <= '0;
      lap_count  <= '0;
      disp       <= '0;
    end else begin
      state      <= state_next;
      o_runstop  <= (state_next == RUN) || (state_next == LAP);
      o_clear    <= (state_next == CLR);
      lap_active <= (state_next == LAP);
      if (state_next == CLR) begin
        lap_snap  <= '0;
        lap_count <= '0;
      end else if (state == RUN && state_next == LAP) begin
        lap_snap  <= live;
        lap_count <= sat_inc(lap_count);
      end
      // On the entry edge the snapshot and the live value are the same sample.
      disp <= (state == LAP && state_next == LAP) ? lap_snap : live;
    end
  end

  assign disp_msec = disp.msec;
  assign disp_sec  = disp.sec;
  assign disp_min  = disp.min;
  assign disp_hour = disp.hour;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl with DEBOUNCE_CYCLES = 4.
module tb_stopwatch_lap_ctrl;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       btn_runstop;
  logic       btn_clear;
  logic       btn_lap;
  logic [6:0] live_msec;
  logic [5:0] live_sec;
  logic [5:0] live_min;
  logic [4:0] live_hour;
  logic       o_runstop;
  logic       o_clear;
  logic [6:0] disp_msec;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic [4:0] disp_hour;
  logic       lap_active;
  logic [3:0] lap_count;

  stopwatch_lap_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .btn_runstop(btn_runstop), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .live_msec(live_msec), .live_sec(live_sec), .live_min(live_min), .live_hour(live_hour),
    .o_runstop(o_runstop), .o_clear(o_clear),
    .disp_msec(disp_msec), .disp_sec(disp_sec), .disp_min(disp_min), .disp_hour(disp_hour),
    .lap_active(lap_active), .lap_count(lap_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: a level is accepted after D consecutive differing synchronized
  // samples; an accepted press acts on the machine two edges later.
  bit   m_s1[3], m_s2[3], m_acc[3], m_p1[3], m_p2[3];
  int   m_run[3];
  bit   running, frozen, clearing;
  int   laps;
  int   snap[4];
  int   exp_disp[4];

  task automatic model_step();
    bit raw[3];
    bit ev[3];
    bit s;
    raw[0] = btn_runstop; raw[1] = btn_clear; raw[2] = btn_lap;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_p1[b] = 0; m_p2[b] = 0; m_run[b] = 0;
      end
      running = 0; frozen = 0; clearing = 0; laps = 0;
      for (int k = 0; k < 4; k++) begin snap[k] = 0; exp_disp[k] = 0; end
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b]   = m_p2[b];
      m_p2[b] = m_p1[b];
      m_p1[b] = 0;
      s       = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
      if (s != m_acc[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_acc[b] = s;
          m_run[b] = 0;
          if (s) m_p1[b] = 1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (clearing) begin
      clearing = 0;
    end else if (!running) begin
      if (ev[0]) running = 1;
      else if (ev[1]) begin
        clearing = 1; laps = 0;
        for (int k = 0; k < 4; k++) snap[k] = 0;
      end
    end else begin
      if (ev[0]) begin
        running = 0; frozen = 0;
      end else if (!ev[1] && ev[2]) begin
        if (frozen) frozen = 0;
        else begin
          frozen = 1;
          snap[0] = live_msec; snap[1] = live_sec; snap[2] = live_min; snap[3] = live_hour;
          laps = (laps < 15) ? laps + 1 : 15;
        end
      end
    end
    if (frozen) begin
      for (int k = 0; k < 4; k++) exp_disp[k] = snap[k];
    end else begin
      exp_disp[0] = live_msec; exp_disp[1] = live_sec;
      exp_disp[2] = live_min;  exp_disp[3] = live_hour;
    end
  endtask

  // ---------------- driver ----------------
  bit hold_live = 0;
  int clr_seen  = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("runstop", 32'(o_runstop), 32'(running));
    check("clear", 32'(o_clear), 32'(clearing));
    check("lap_active", 32'(lap_active), 32'(frozen));
    check("lap_count", 32'(lap_count), 32'(laps));
    check("disp_msec", 32'(disp_msec), 32'(exp_disp[0]));
    check("disp_sec", 32'(disp_sec), 32'(exp_disp[1]));
    check("disp_min", 32'(disp_min), 32'(exp_disp[2]));
    check("disp_hour", 32'(disp_hour), 32'(exp_disp[3]));
    if (o_clear) clr_seen++;
    if (!hold_live) begin
      live_msec = 7'($urandom_range(0, 99));
      live_sec  = 6'($urandom_range(0, 59));
      live_min  = 6'($urandom_range(0, 59));
      live_hour = 5'($urandom_range(0, 23));
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int rel);
    btn_runstop = mask[0]; btn_clear = mask[1]; btn_lap = mask[2];
    repeat (hold) tick();
    btn_runstop = 0; btn_clear = 0; btn_lap = 0;
    repeat (rel) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int l_ms, l_s;
    rst = 1; btn_runstop = 0; btn_clear = 0; btn_lap = 0;
    live_msec = 0; live_sec = 0; live_min = 0; live_hour = 0;
    repeat (3) tick();
    check("reset_runstop", 32'(o_runstop), 32'd0);
    check("reset_disp", 32'(disp_msec), 32'd0);
    check("reset_laps", 32'(lap_count), 32'd0);
    rst = 0;
    tick();

    // run/stop latency: first sample on tick 1, state changes on tick D+4
    first = 0;
    btn_runstop = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (o_runstop && first == 0) first = i;
    end
    btn_runstop = 0;
    repeat (8) tick();
    check("runstop_latency", 32'(first), 32'(D + 4));
    press(3'b001, 8, 8);
    check("runstop_second", 32'(o_runstop), 32'd0);

    // bounce rejection
    for (int i = 0; i < 20; i++) begin
      btn_runstop = ((i / 2) % 2) == 0;
      tick();
    end
    btn_runstop = 0;
    repeat (12) tick();
    check("bounce_stop", 32'(o_runstop), 32'd0);

    // lap freeze
    press(3'b001, 8, 8);
    hold_live = 1;
    live_msec = 12; live_sec = 34; live_min = 5; live_hour = 1;
    press(3'b100, 8, 8);
    hold_live = 0;
    check("lap_enter", 32'(lap_active), 32'd1);
    check("lap_cnt1", 32'(lap_count), 32'd1);
    repeat (5) tick();
    check("frz_msec", 32'(disp_msec), 32'd12);
    check("frz_sec", 32'(disp_sec), 32'd34);
    check("frz_min", 32'(disp_min), 32'd5);
    check("frz_hour", 32'(disp_hour), 32'd1);
    press(3'b100, 8, 8);
    check("lap_exit", 32'(lap_active), 32'd0);
    l_ms = live_msec; l_s = live_sec;
    tick();
    check("live_follow_ms", 32'(disp_msec), 32'(l_ms));
    check("live_follow_s", 32'(disp_sec), 32'(l_s));

    // clear from STOP with three laps
    press(3'b100, 8, 8);
    press(3'b100, 8, 8);
    press(3'b100, 8, 8);
    press(3'b001, 8, 8);
    check("laps_before_clr", 32'(lap_count), 32'd3);
    clr_seen = 0;
    press(3'b010, 8, 8);
    check("clr_one_cycle", 32'(clr_seen), 32'd1);
    check("clr_laps", 32'(lap_count), 32'd0);
    check("clr_stop", 32'(o_runstop), 32'd0);
    press(3'b001, 8, 8);
    clr_seen = 0;
    press(3'b010, 8, 8);
    check("clr_in_run", 32'(clr_seen), 32'd0);
    check("run_kept", 32'(o_runstop), 32'd1);

    // simultaneous runstop + clear from STOP
    press(3'b001, 8, 8);
    clr_seen = 0;
    press(3'b011, 8, 8);
    check("simul_run", 32'(o_runstop), 32'd1);
    check("simul_noclr", 32'(clr_seen), 32'd0);

    // lap counter saturation
    for (int i = 0; i < 32; i++) press(3'b100, 8, 8);
    check("lap_sat", 32'(lap_count), 32'd15);

    // reset while in LAP
    press(3'b100, 8, 8);
    check("lap_before_rst", 32'(lap_active), 32'd1);
    rst = 1;
    tick();
    check("rst_lap_active", 32'(lap_active), 32'd0);
    check("rst_runstop", 32'(o_runstop), 32'd0);
    check("rst_disp_sec", 32'(disp_sec), 32'd0);
    rst = 0;

    // randomized traffic, including bounces and occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [2:0] mask;
      mask = 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 39) == 0) rst = 1;
      btn_runstop = mask[0]; btn_clear = mask[1]; btn_lap = mask[2];
      repeat ($urandom_range(1, 9)) begin
        tick();
        rst = 0;
      end
      btn_runstop = 0; btn_clear = 0; btn_lap = 0;
      repeat ($urandom_range(1, 9)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
